// File: rtl/pipe_pkg.sv
// Shared encodings for the Y86-64 pipeline controller: icodes, status codes,
// register "none" marker and the controller state encoding.
package pipe_pkg;

    localparam int unsigned ICODE_W = 4;
    localparam int unsigned STAT_W  = 4;

    localparam logic [ICODE_W-1:0] IHALT   = 4'h0;
    localparam logic [ICODE_W-1:0] INOP    = 4'h1;
    localparam logic [ICODE_W-1:0] IRRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] IIRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] IRMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
    localparam logic [ICODE_W-1:0] ICALL   = 4'h8;
    localparam logic [ICODE_W-1:0] IRET    = 4'h9;
    localparam logic [ICODE_W-1:0] IPUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

    localparam logic [STAT_W-1:0] SAOK = 4'h1;
    localparam logic [STAT_W-1:0] SHLT = 4'h2;
    localparam logic [STAT_W-1:0] SADR = 4'h3;
    localparam logic [STAT_W-1:0] SINS = 4'h4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Any status that must terminate the machine.
    function automatic logic is_exc(input logic [STAT_W-1:0] stat);
        return (stat == SHLT) || (stat == SADR) || (stat == SINS);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline-state inputs and stage-control outputs of pipe_ctrl.
// Perf counter signals exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if #(parameter int unsigned CNT_W = 32);

    logic [3:0]       D_icode;
    logic [3:0]       E_icode;
    logic [3:0]       M_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       m_stat;
    logic [3:0]       W_stat;

    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             set_cc_en;
    logic             halted;
    logic [3:0]       exc_code;
    logic [CNT_W-1:0] cycle_cnt;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic [CNT_W-1:0] mp_cnt;
`endif

    modport master (
        output D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_Cnd, m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        input  set_cc_en, halted, exc_code, cycle_cnt
`ifdef PIPE_CTRL_PERF_EN
        , input lu_cnt, ret_cnt, mp_cnt
`endif
    );

    modport slave (
        input  D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_Cnd, m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        output set_cc_en, halted, exc_code, cycle_cnt
`ifdef PIPE_CTRL_PERF_EN
        , output lu_cnt, ret_cnt, mp_cnt
`endif
    );

endinterface

// File: rtl/pipe_hazard_det.sv
// Combinational hazard detection: load/use, return-in-flight and mispredict.
module pipe_hazard_det
    import pipe_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] E_icode,
    input  logic [3:0] M_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    output logic       lu_c,
    output logic       ret_c,
    output logic       mp_c
);

    always_comb begin
        lu_c  = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) &&
                (E_dstM != RNONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        ret_c = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
        mp_c  = (E_icode == IJXX) && !e_Cnd;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/exception controller: RUN/DRAIN/HALTED FSM, stage controls, counters.
// Optional PIPE_CTRL_PERF_EN adds lu/ret/mp event counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic [3:0]       exc_code_q, exc_code_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    logic lu_c, ret_c, mp_c;
    logic f_stall_c, d_stall_c, d_bubble_c, e_bubble_c, m_bubble_c, w_stall_c;
    logic set_cc_en_c, halted_c;
    logic m_exc_c, w_exc_c;

    pipe_hazard_det u_hazard (
        .D_icode (bus.D_icode),
        .E_icode (bus.E_icode),
        .M_icode (bus.M_icode),
        .d_srcA  (bus.d_srcA),
        .d_srcB  (bus.d_srcB),
        .E_dstM  (bus.E_dstM),
        .e_Cnd   (bus.e_Cnd),
        .lu_c    (lu_c),
        .ret_c   (ret_c),
        .mp_c    (mp_c)
    );

    assign m_exc_c = is_exc(bus.m_stat);
    assign w_exc_c = is_exc(bus.W_stat);

    // Next state and per-state stage controls.
    always_comb begin
        state_d     = state_q;
        f_stall_c   = 1'b0;
        d_stall_c   = 1'b0;
        d_bubble_c  = 1'b0;
        e_bubble_c  = 1'b0;
        m_bubble_c  = 1'b0;
        w_stall_c   = 1'b0;
        set_cc_en_c = 1'b0;
        halted_c    = 1'b0;
        case (state_q)
            ST_RUN: begin
                f_stall_c   = lu_c | ret_c;
                d_stall_c   = lu_c;
                d_bubble_c  = mp_c | (ret_c & ~lu_c);
                e_bubble_c  = mp_c | lu_c;
                m_bubble_c  = m_exc_c | w_exc_c;
                w_stall_c   = w_exc_c;
                set_cc_en_c = ~(m_exc_c | w_exc_c);
                if (w_exc_c) begin
                    state_d = ST_HALTED;
                end else if (m_exc_c) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                f_stall_c  = 1'b1;
                d_bubble_c = 1'b1;
                e_bubble_c = 1'b1;
                m_bubble_c = 1'b1;
                if (w_exc_c) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                f_stall_c = 1'b1;
                d_stall_c = 1'b1;
                w_stall_c = 1'b1;
                halted_c  = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Status capture on HALTED entry; cycle counter frozen once halted.
    always_comb begin
        exc_code_d  = exc_code_q;
        cycle_cnt_d = cycle_cnt_q;
        if ((state_q != ST_HALTED) && (state_d == ST_HALTED)) begin
            exc_code_d = bus.W_stat;
        end
        if (state_q != ST_HALTED) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            exc_code_q  <= SAOK;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            exc_code_q  <= exc_code_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

    // Hazard event counters advance only while running.
    always_comb begin
        lu_cnt_d  = lu_cnt_q;
        ret_cnt_d = ret_cnt_q;
        mp_cnt_d  = mp_cnt_q;
        if (state_q == ST_RUN) begin
            if (lu_c)           lu_cnt_d  = lu_cnt_q + CNT_W'(1);
            if (ret_c && !lu_c) ret_cnt_d = ret_cnt_q + CNT_W'(1);
            if (mp_c)           mp_cnt_d  = mp_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt_q  <= '0;
            ret_cnt_q <= '0;
            mp_cnt_q  <= '0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            ret_cnt_q <= ret_cnt_d;
            mp_cnt_q  <= mp_cnt_d;
        end
    end

    assign bus.lu_cnt  = lu_cnt_q;
    assign bus.ret_cnt = ret_cnt_q;
    assign bus.mp_cnt  = mp_cnt_q;
`endif

    assign bus.F_stall   = f_stall_c;
    assign bus.D_stall   = d_stall_c;
    assign bus.D_bubble  = d_bubble_c;
    assign bus.E_bubble  = e_bubble_c;
    assign bus.M_bubble  = m_bubble_c;
    assign bus.W_stall   = w_stall_c;
    assign bus.set_cc_en = set_cc_en_c;
    assign bus.halted    = halted_c;
    assign bus.exc_code  = exc_code_q;
    assign bus.cycle_cnt = cycle_cnt_q;

endmodule
